// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - start/busy/done handshake bundle for the multi-cycle shifter
interface seq_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
);
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] in;
  logic [AMTW-1:0]  amt;
  logic [WIDTH-1:0] sout;
  logic             carry;
  logic             busy;
  logic             done;

  // controller side: issues requests, observes result and status
  modport master (
    output start, mode, in, amt,
    input  sout, carry, busy, done
  );

  // shifter side
  modport slave (
    input  start, mode, in, amt,
    output sout, carry, busy, done
  );
endinterface

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle logical/arithmetic/rotate shifter, one bit per clock
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic        clk,
  input  logic        reset,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] MODE_LSL = 3'b001;
  localparam logic [2:0] MODE_LSR = 3'b010;
  localparam logic [2:0] MODE_ASR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_ROR = 3'b101;

  state_t           state;
  logic [2:0]       mode_q;
  logic [AMTW-1:0]  count;
  logic [WIDTH-1:0] sout_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             shifting_mode;

  // pass and the two reserved encodings complete without any shifting
  assign shifting_mode = (bus.mode == MODE_LSL) || (bus.mode == MODE_LSR) ||
                         (bus.mode == MODE_ASR) || (bus.mode == MODE_ROL) ||
                         (bus.mode == MODE_ROR);

  assign bus.sout  = sout_q;
  assign bus.carry = carry_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // control FSM and datapath: capture on start, shift once per cycle, pulse done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= 3'b000;
      count   <= '0;
      sout_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            sout_q  <= bus.in;
            carry_q <= 1'b0;
            mode_q  <= bus.mode;
            count   <= bus.amt;
            busy_q  <= 1'b1;
            if (bus.amt == '0 || !shifting_mode) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          case (mode_q)
            MODE_LSL: begin
              sout_q  <= {sout_q[WIDTH-2:0], 1'b0};
              carry_q <= sout_q[WIDTH-1];
            end
            MODE_LSR: begin
              sout_q  <= {1'b0, sout_q[WIDTH-1:1]};
              carry_q <= sout_q[0];
            end
            MODE_ASR: begin
              sout_q  <= {sout_q[WIDTH-1], sout_q[WIDTH-1:1]};
              carry_q <= sout_q[0];
            end
            MODE_ROL: begin
              sout_q  <= {sout_q[WIDTH-2:0], sout_q[WIDTH-1]};
              carry_q <= sout_q[WIDTH-1];
            end
            MODE_ROR: begin
              sout_q  <= {sout_q[0], sout_q[WIDTH-1:1]};
              carry_q <= sout_q[0];
            end
            default: begin
              sout_q  <= sout_q;
              carry_q <= carry_q;
            end
          endcase
          count <= count - 1'b1;
          if (count == {{(AMTW-1){1'b0}}, 1'b1}) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed self-checking bench for seq_shifter
module tb_seq_shifter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  seq_shifter_if #(.WIDTH(16), .AMTW(4)) bus ();

  seq_shifter #(.WIDTH(16), .AMTW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue one request and check latency, result, carry and the done/busy pulse
  task automatic run(input string tag, input logic [2:0] m, input logic [15:0] d,
                     input logic [3:0] a, input int exp_lat,
                     input logic [15:0] exp_sout, input logic exp_carry);
    int lat;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.in    = d;
    bus.amt   = a;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      chk({tag, "_busy_wait"}, {31'd0, bus.busy}, 32'd1);
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_sout"}, {16'd0, bus.sout}, {16'd0, exp_sout});
    chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, exp_carry});
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    tick();
    chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_hold"}, {16'd0, bus.sout}, {16'd0, exp_sout});
  endtask

  initial begin
    int dones;
    logic [11:0] done_v;
    logic [11:0] busy_v;

    bus.start = 1'b0;
    bus.mode  = 3'b000;
    bus.in    = 16'h0000;
    bus.amt   = 4'd0;
    #12;
    chk("rst_sout", {16'd0, bus.sout}, 32'd0);
    chk("rst_carry", {31'd0, bus.carry}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    tick();

    run("lsl1",   3'b001, 16'h8001, 4'd1,  1,  16'h0002, 1'b1);
    run("asr15",  3'b011, 16'h8000, 4'd15, 15, 16'hFFFF, 1'b0);
    run("lsr15",  3'b010, 16'hFFFF, 4'd15, 15, 16'h0001, 1'b1);
    run("rol4",   3'b100, 16'h8421, 4'd4,  4,  16'h4218, 1'b0);
    run("ror1",   3'b101, 16'h0001, 4'd1,  1,  16'h8000, 1'b1);
    run("rol15",  3'b100, 16'hA5C3, 4'd15, 15, 16'hD2E1, 1'b1);
    run("amt0",   3'b001, 16'h1234, 4'd0,  0,  16'h1234, 1'b0);
    run("pass",   3'b000, 16'h5A5A, 4'd7,  0,  16'h5A5A, 1'b0);

    // reserved mode with start held through DONE: exactly one done pulse
    bus.start = 1'b1;
    bus.mode  = 3'b111;
    bus.in    = 16'hBEEF;
    bus.amt   = 4'd9;
    tick();
    chk("m111_done", {31'd0, bus.done}, 32'd1);
    chk("m111_sout", {16'd0, bus.sout}, 32'h0000BEEF);
    chk("m111_carry", {31'd0, bus.carry}, 32'd0);
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    chk("m111_single_done", dones, 0);

    // asynchronous reset in the middle of a long lsr
    bus.start = 1'b1;
    bus.mode  = 3'b010;
    bus.in    = 16'hF0F1;
    bus.amt   = 4'd10;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_sout", {16'd0, bus.sout}, 32'd0);
    chk("abort_carry", {31'd0, bus.carry}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    #2 reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    chk("abort_no_resume", dones, 0);
    run("post_rst", 3'b001, 16'h0003, 4'd2, 2, 16'h000C, 1'b0);

    // start held high: re-trigger every time IDLE is reached
    bus.start = 1'b1;
    bus.mode  = 3'b001;
    bus.in    = 16'h0003;
    bus.amt   = 4'd2;
    for (int i = 0; i < 12; i++) begin
      tick();
      done_v[i] = bus.done;
      busy_v[i] = bus.busy;
    end
    bus.start = 1'b0;
    chk("held_done_pattern", {20'd0, done_v}, {20'd0, 12'b0100_0100_0100});
    chk("held_busy_pattern", {20'd0, busy_v}, {20'd0, 12'b0111_0111_0111});
    tick();
    tick();
    tick();
    chk("held_final_sout", {16'd0, bus.sout}, 32'h0000000C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised multi-cycle shifter that performs a logical, arithmetic or rotate shift by a run-time amount, one bit position per clock.
It sits beside the datapath ALU and is started by the controller FSM with a start/busy/done handshake.
It also reports the last bit shifted out (carry) for status flags.
Mode encoding extends the existing 2-bit shift operations (pass, left, right, arithmetic right) with rotates.

Parameters:
WIDTH, 16, data width in bits (>=2)
AMTW, 4, width of the shift-amount input; maximum amount is 2^AMTW-1 (may exceed WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  3  000 pass, 001 lsl, 010 lsr, 011 asr, 100 rol, 101 ror, 110/111 treated as pass
in  input  WIDTH  operand, captured on accepted start
amt  input  AMTW  shift amount, captured on accepted start
sout  output  WIDTH  result register
carry  output  1  last bit shifted or rotated out
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, active-high): state=IDLE, sout=0, carry=0, busy=0, done=0, internal count=0. Reset mid-operation aborts with no done pulse; the operation is not resumed.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE, start=1 at edge E0 (accept):
  - sout<=in, carry<=0, mode latched, count<=amt.
  - If amt==0 or mode is pass/110/111, go to DONE; otherwise go to SHIFT.
- SHIFT, each edge:
  - lsl: sout<={sout[W-2:0],0}, carry<=sout[W-1].
  - lsr: sout<={0,sout[W-1:1]}, carry<=sout[0].
  - asr: sout<={sout[W-1],sout[W-1:1]}, carry<=sout[0].
  - rol: sout<={sout[W-2:0],sout[W-1]}, carry<=sout[W-1].
  - ror: sout<={sout[0],sout[W-1:1]}, carry<=sout[0].
  - count decrements; if count==1 before the edge, go to DONE.
- Latency: done is high in the cycle after edge E_amt (amt>=1), or after E0 when amt==0 or mode is pass. done is high for exactly one cycle.
- DONE: done=1, busy=1; unconditionally go to IDLE on the next edge, where done=0 and busy=0.
- sout and carry hold their values in IDLE until the next accepted start.
- Minimum start-to-start interval is amt+2 cycles.
- start in SHIFT or DONE is ignored (no queueing). start held high in IDLE re-triggers every time IDLE is reached.
- amt>=WIDTH: shifting continues for the full count.
  - lsl/lsr result: 0.
  - asr result: all bits equal to the sign.
  - Rotates wrap modulo WIDTH (e.g., rol by WIDTH returns the original value).
- Intermediate sout values during SHIFT are not architectural; consumers sample sout only on done or afterwards.

Test Plan:
- lsl, in=16'h8001, amt=1 -> done one cycle after E1; sout=16'h0002, carry=1; busy high for 2 cycles.
- asr, in=16'h8000, amt=15 -> done after E15; sout=16'hFFFF, carry=0. lsr, in=16'hFFFF, amt=15 -> sout=16'h0001, carry=1.
- rol, in=16'h8421, amt=4 -> sout=16'h4218, carry=0. ror, in=16'h0001, amt=1 -> sout=16'h8000, carry=1. rol, in=16'hA5C3, amt=15 -> sout=16'hD2E1.
- amt=0 (lsl, in=16'h1234) and mode=3'b111 (amt=9, in=16'hBEEF) -> done the cycle after E0; sout equals in, carry=0. A start pulse while busy is ignored, so only one done pulse occurs.
- Reset asserted asynchronously mid-edge during SHIFT (lsr, amt=10, after 3 shifts) -> sout/carry/busy/done go to 0 immediately, no done pulse. A following start (lsl, 16'h0003, amt=2) gives sout=16'h000C.
- start held high continuously with amt=2 -> done pulses every 4 cycles; busy low exactly one cycle between operations.
